// File: rtl/fixed_softsign_pkg.sv
// Shared defaults for the fixed-point softsign activation block.
package fixed_softsign_pkg;

  localparam int unsigned DEF_IN_W   = 16;
  localparam int unsigned DEF_IN_FI  = 8;
  localparam int unsigned DEF_OUT_W  = 28;
  localparam int unsigned DEF_OUT_FO = 24;
  localparam int unsigned DEF_DIM    = 1;

endpackage

// File: rtl/fixed_softsign_lane.sv
// Combinational softsign for one lane: y = x / (1 + |x|) via exact restoring division.
module fixed_softsign_lane #(
  parameter int IN_W  = 16,
  parameter int FI    = 8,
  parameter int OUT_W = 28,
  parameter int FO    = 24
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [OUT_W-1:0] o_y
);

  localparam int unsigned MAG_W = IN_W + 1;
  localparam int unsigned DIV_W = FO + IN_W + 1;
  localparam logic [MAG_W-1:0] ONE = MAG_W'(1) << FI;

  logic             w_neg;
  logic [MAG_W-1:0] w_x_ext;
  logic [MAG_W-1:0] w_mag;
  logic [MAG_W-1:0] w_den;
  logic [DIV_W-1:0] w_num;
  logic [DIV_W-1:0] w_quo;
  logic [OUT_W-1:0] w_q_ext;

  // Unsigned restoring long division; remainder carries one guard bit.
  function automatic logic [DIV_W-1:0] udiv(input logic [DIV_W-1:0] n,
                                            input logic [MAG_W-1:0] d);
    logic [MAG_W:0]   rem;
    logic [DIV_W-1:0] q;
    rem = '0;
    q   = '0;
    for (int i = DIV_W - 1; i >= 0; i--) begin
      rem = {rem[MAG_W-1:0], n[i]};
      if (rem >= {1'b0, d}) begin
        rem  = rem - {1'b0, d};
        q[i] = 1'b1;
      end
    end
    return q;
  endfunction

  // Magnitude is one bit wider so the most negative input stays exact.
  always_comb begin
    w_neg   = i_x[IN_W-1];
    w_x_ext = {i_x[IN_W-1], i_x};
    w_mag   = w_neg ? (-w_x_ext) : w_x_ext;
    w_den   = ONE + w_mag;
    w_num   = {w_mag, {FO{1'b0}}};
    w_quo   = udiv(w_num, w_den);
    w_q_ext = OUT_W'(w_quo);
    o_y     = w_neg ? (-w_q_ext) : w_q_ext;
  end

endmodule

// File: rtl/fixed_softsign.sv
// Lane-parallel softsign activation with a single registered valid/ready output stage.
module fixed_softsign
  import fixed_softsign_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0        = DEF_IN_W,
  parameter int DATA_IN_0_PRECISION_1        = DEF_IN_FI,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = DEF_DIM,
  parameter int DATA_IN_0_PARALLELISM_DIM_1  = DEF_DIM,
  parameter int DATA_OUT_0_PRECISION_0       = DEF_OUT_W,
  parameter int DATA_OUT_0_PRECISION_1       = DEF_OUT_FO,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic data_out_0_valid,
  input  logic data_out_0_ready
);

  localparam int unsigned IN_W  = DATA_IN_0_PRECISION_0;
  localparam int unsigned FI    = DATA_IN_0_PRECISION_1;
  localparam int unsigned OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int unsigned FO    = DATA_OUT_0_PRECISION_1;
  localparam int unsigned N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;

  // Reject configurations where the result cannot hold sign plus FO fraction bits.
  if (DATA_OUT_0_PRECISION_0 < DATA_OUT_0_PRECISION_1 + 2) begin : g_bad_width
    $error("fixed_softsign: output width must be at least FO+2");
  end
  if ((DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0) ||
      (DATA_OUT_0_PARALLELISM_DIM_1 != DATA_IN_0_PARALLELISM_DIM_1)) begin : g_bad_par
    $error("fixed_softsign: output parallelism must equal input parallelism");
  end

  logic             r_valid;
  logic [OUT_W-1:0] r_data [N];
  logic [OUT_W-1:0] w_y    [N];
  logic             w_in_fire;

  // One combinational softsign unit per lane.
  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    fixed_softsign_lane #(
      .IN_W  (IN_W),
      .FI    (FI),
      .OUT_W (OUT_W),
      .FO    (FO)
    ) u_lane (
      .i_x (data_in_0[g]),
      .o_y (w_y[g])
    );
  end

  // Accept whenever the output slot is empty or being drained this cycle.
  assign data_in_0_ready = !r_valid || data_out_0_ready;
  assign w_in_fire       = data_in_0_valid && data_in_0_ready;

  // Output register: fill on input transfer, clear valid on drain-only, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_data[i] <= '0;
      end
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_y;
    end else if (r_valid && data_out_0_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out_0_valid = r_valid;
  assign data_out_0       = r_data;

endmodule

// File: tb/tb_fixed_softsign.sv
// Directed self-checking bench for fixed_softsign with two lanes.
module tb_fixed_softsign;

  localparam int IN_W  = 16;
  localparam int OUT_W = 28;
  localparam int N     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  din  [N];
  logic             din_valid;
  logic             din_ready;
  logic [OUT_W-1:0] dout [N];
  logic             dout_valid;
  logic             dout_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fixed_softsign #(
    .DATA_IN_0_PARALLELISM_DIM_0 (2),
    .DATA_IN_0_PARALLELISM_DIM_1 (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (din),
    .data_in_0_valid  (din_valid),
    .data_in_0_ready  (din_ready),
    .data_out_0       (dout),
    .data_out_0_valid (dout_valid),
    .data_out_0_ready (dout_ready)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: floor(m * 2^24 / (256 + m)) with the sign of x restored.
  function automatic longint model(input longint x);
    longint m;
    longint q;
    m = (x < 0) ? -x : x;
    q = (m * 64'sd16777216) / (64'sd256 + m);
    return (x < 0) ? -q : q;
  endfunction

  function automatic longint lane_out(input int i);
    longint v;
    v = longint'($signed(dout[i]));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint a, input longint b, input logic v);
    din[0]    = IN_W'(a);
    din[1]    = IN_W'(b);
    din_valid = v;
  endtask

  longint spot_x [7] = '{0, 256, -256, 128, 768, -16384, -32768};
  longint spot_y [7] = '{0, 8388608, -8388608, 5592405, 12582912, -16519104, -16647160};
  longint tp_x   [3] = '{256, 512, 768};
  longint tp_y   [3] = '{8388608, 11184810, 12582912};

  initial begin
    rst        = 1'b1;
    dout_ready = 1'b1;
    drive(0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_val("reset_valid", longint'(dout_valid), 0);
    check_val("reset_lane0", lane_out(0), 0);
    check_val("reset_lane1", lane_out(1), 0);
    check_val("reset_in_ready", longint'(din_ready), 1);

    // Spot values on lane 0, lane 1 held at zero.
    for (int k = 0; k < 7; k++) begin
      drive(spot_x[k], 0, 1'b1);
      tick();
      check_val($sformatf("spot_x%0d", spot_x[k]), lane_out(0), spot_y[k]);
      check_val("spot_lane1_zero", lane_out(1), 0);
      check_val("spot_valid", longint'(dout_valid), 1);
    end

    // Lanes carry unrelated values in the same beat.
    drive(256, -768, 1'b1);
    tick();
    check_val("indep_lane0", lane_out(0), 8388608);
    check_val("indep_lane1", lane_out(1), -12582912);

    // Back-to-back beats produce back-to-back results.
    for (int k = 0; k < 3; k++) begin
      drive(tp_x[k], -tp_x[k], 1'b1);
      tick();
      check_val("tput_valid", longint'(dout_valid), 1);
      check_val($sformatf("tput_lane0_%0d", k), lane_out(0), tp_y[k]);
      check_val($sformatf("tput_lane1_%0d", k), lane_out(1), -tp_y[k]);
    end

    // Full sweep at one beat per cycle.
    for (int x = -16384; x < 16384; x += 2) begin
      drive(longint'(x), longint'(x + 1), 1'b1);
      tick();
      check_val("sweep_valid", longint'(dout_valid), 1);
      check_val($sformatf("sweep_x%0d", x), lane_out(0), model(longint'(x)));
      check_val($sformatf("sweep_x%0d", x + 1), lane_out(1), model(longint'(x + 1)));
    end

    // Backpressure: result pending while downstream stalls.
    drive(0, 0, 1'b0);
    tick();
    check_val("drain_valid", longint'(dout_valid), 0);
    dout_ready = 1'b0;
    drive(256, -768, 1'b1);
    tick();
    check_val("bp_load_valid", longint'(dout_valid), 1);
    drive(512, -512, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_val("bp_in_ready", longint'(din_ready), 0);
      check_val("bp_valid", longint'(dout_valid), 1);
      check_val("bp_lane0", lane_out(0), 8388608);
      check_val("bp_lane1", lane_out(1), -12582912);
      tick();
    end
    dout_ready = 1'b1;
    #1;
    check_val("bp_release_ready", longint'(din_ready), 1);
    tick();
    check_val("bp_next_valid", longint'(dout_valid), 1);
    check_val("bp_next_lane0", lane_out(0), 11184810);
    check_val("bp_next_lane1", lane_out(1), -11184810);
    drive(0, 0, 1'b0);
    tick();
    check_val("bp_empty_valid", longint'(dout_valid), 0);
    check_val("bp_hold_lane0", lane_out(0), 11184810);

    // Reset while a result is held.
    dout_ready = 1'b0;
    drive(768, 128, 1'b1);
    tick();
    check_val("rst_pre_valid", longint'(dout_valid), 1);
    check_val("rst_pre_lane1", lane_out(1), 5592405);
    rst = 1'b1;
    drive(0, 0, 1'b0);
    tick();
    check_val("rst_mid_valid", longint'(dout_valid), 0);
    check_val("rst_mid_lane0", lane_out(0), 0);
    check_val("rst_mid_lane1", lane_out(1), 0);
    rst = 1'b0;
    tick();
    check_val("rst_post_ready", longint'(din_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
